muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit sitting beside the ALU, directly downstream of the register file. It consumes the two register read ports (rd1/rd2) as operands, computes any of the eight M-extension operations over multiple cycles, and returns a 32-bit result with the destination index for the register-file write port (wd3/a3/we3). The core stalls on `busy` and writes back on `done`.

---
 rtl/muldiv_pkg.sv | 30 +++
 rtl/muldiv_unit.sv | 174 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_pkg : shared types and constants for the RV32M mul/div unit    |
// | Revision   : 1.0                                                      |
// +----------------------------------------------------------------------+
package muldiv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [XLEN-1:0] DIV0_Q = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] OVF_Q  = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_unit : iterative RV32M multiply/divide, one bit per cycle      |
// | Revision    : 1.0                                                     |
// +----------------------------------------------------------------------+
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      rd,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      wb_addr,
    output logic            wb_we
);

    localparam int DW = 2 * XLEN;

    state_t          state_q, state_d;
    logic [5:0]      count_q, count_d;
    logic [2:0]      f3_q, f3_d;
    logic [4:0]      wb_addr_q, wb_addr_d;
    logic [DW-1:0]   acc_q, acc_d;
    logic [XLEN-1:0] opb_q, opb_d;
    logic            neg_q, neg_d;
    logic            rneg_q, rneg_d;
    logic            div0_q, div0_d;
    logic            ovf_q, ovf_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // Operand conditioning at capture time
    logic            sign_a, sign_b, a_neg, b_neg, div0_in, ovf_in;
    logic [XLEN-1:0] a_mag, b_mag;

    assign sign_a  = (funct3 != F3_MULHU) && (funct3 != F3_DIVU) && (funct3 != F3_REMU);
    assign sign_b  = (funct3 == F3_MUL) || (funct3 == F3_MULH) ||
                     (funct3 == F3_DIV) || (funct3 == F3_REM);
    assign a_neg   = sign_a & a[XLEN-1];
    assign b_neg   = sign_b & b[XLEN-1];
    assign a_mag   = a_neg ? -a : a;
    assign b_mag   = b_neg ? -b : b;
    assign div0_in = funct3[2] && (b == '0);
    assign ovf_in  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) && (a == OVF_Q) && (b == '1);

    // Multiply step: accumulate into upper half, shift the pair right.
    logic [XLEN:0]   mul_sum;
    logic [DW-1:0]   mul_step;
    assign mul_sum  = {1'b0, acc_q[DW-1:XLEN]} + {1'b0, opb_q};
    assign mul_step = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[DW-1:1]};

    // Restoring divide step: the shifted remainder needs one extra bit.
    logic [XLEN:0]   div_rem_sh, div_diff;
    logic [DW-1:0]   div_step;
    assign div_rem_sh = acc_q[DW-1:XLEN-1];
    assign div_diff   = div_rem_sh - {1'b0, opb_q};
    assign div_step   = div_diff[XLEN] ? {acc_q[DW-2:0], 1'b0}
                                       : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    // Sign fix-up and output selection
    logic [DW-1:0]   prod;
    logic [XLEN-1:0] quo, rem, fix_res;
    assign prod = neg_q  ? -acc_q : acc_q;
    assign quo  = neg_q  ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem  = rneg_q ? -acc_q[DW-1:XLEN] : acc_q[DW-1:XLEN];

    always_comb begin
        fix_res = '0;
        if (div0_q) begin
            fix_res = f3_q[1] ? acc_q[XLEN-1:0] : DIV0_Q;
        end else if (ovf_q) begin
            fix_res = f3_q[1] ? '0 : OVF_Q;
        end else begin
            case (f3_q)
                F3_MUL:                     fix_res = prod[XLEN-1:0];
                F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod[DW-1:XLEN];
                F3_DIV, F3_DIVU:            fix_res = quo;
                default:                    fix_res = rem;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        f3_d      = f3_q;
        wb_addr_d = wb_addr_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        neg_d     = neg_q;
        rneg_d    = rneg_q;
        div0_d    = div0_q;
        ovf_d     = ovf_q;
        result_d  = result_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    f3_d      = funct3;
                    wb_addr_d = rd;
                    opb_d     = b_mag;
                    neg_d     = a_neg ^ b_neg;
                    rneg_d    = a_neg;
                    div0_d    = div0_in;
                    ovf_d     = ovf_in;
                    count_d   = '0;
                    // Divide-by-zero keeps the raw dividend as the remainder.
                    acc_d     = {{XLEN{1'b0}}, div0_in ? a : a_mag};
                    state_d   = (div0_in || ovf_in) ? FIX : CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                acc_d   = f3_q[2] ? div_step : mul_step;
                count_d = count_q + 6'd1;
                if (count_q == 6'd31) state_d = FIX;
            end
            FIX: begin
                result_d = fix_res;
                state_d  = DONE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == CALC) || (state_d == FIX);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            f3_q      <= '0;
            wb_addr_q <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            div0_q    <= 1'b0;
            ovf_q     <= 1'b0;
            result_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            f3_q      <= f3_d;
            wb_addr_q <= wb_addr_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            neg_q     <= neg_d;
            rneg_q    <= rneg_d;
            div0_q    <= div0_d;
            ovf_q     <= ovf_d;
            result_q  <= result_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign wb_we   = done_q;
    assign result  = result_q;
    assign wb_addr = wb_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_muldiv_unit : directed vector bench for muldiv_unit                |
// | Revision       : 1.0                                                  |
// +----------------------------------------------------------------------+
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic        busy, done, wb_we;
    logic [31:0] result;
    logic [4:0]  wb_addr;

    int checks   = 0;
    int failures = 0;

    muldiv_unit dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .funct3  (funct3),
        .a       (a),
        .b       (b),
        .rd      (rd),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .wb_addr (wb_addr),
        .wb_we   (wb_we)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Launch one op; lat returns edges from the start-sampling edge to done (-1 on timeout).
    task automatic launch(input logic [2:0] f3, input logic [31:0] va, input logic [31:0] vb,
                          input logic [4:0] vrd);
        @(negedge clk);
        start = 1'b1; funct3 = f3; a = va; b = vb; rd = vrd;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int lat);
        lat = -1;
        for (int n = 1; n <= limit; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int cnt;

        vecs[0]  = '{F3_MUL,    32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33};
        vecs[1]  = '{F3_MULH,   32'h8000_0000,  32'h8000_0000, 5'd1,  32'h4000_0000, 33};
        vecs[2]  = '{F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 33};
        vecs[3]  = '{F3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 33};
        vecs[4]  = '{F3_DIV,    32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFD, 33};
        vecs[5]  = '{F3_REM,    32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFF, 33};
        vecs[6]  = '{F3_DIVU,   32'd100,        32'd7,         5'd7,  32'd14,        33};
        vecs[7]  = '{F3_REMU,   32'd100,        32'd7,         5'd8,  32'd2,         33};
        vecs[8]  = '{F3_DIV,    32'd5,          32'd0,         5'd9,  32'hFFFF_FFFF, 1};
        vecs[9]  = '{F3_REM,    32'd5,          32'd0,         5'd10, 32'd5,         1};
        vecs[10] = '{F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1};
        vecs[11] = '{F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'd0,         1};
        vecs[12] = '{F3_MUL,    32'h1234_5678,  32'h10,        5'd13, 32'h2345_6780, 33};
        vecs[13] = '{F3_MULHU,  32'h1234_5678,  32'h10,        5'd14, 32'h1,         33};
        vecs[14] = '{F3_DIV,    32'hFFFF_FF9C,  32'd7,         5'd15, 32'hFFFF_FFF2, 33};
        vecs[15] = '{F3_REM,    32'hFFFF_FF9C,  32'd7,         5'd16, 32'hFFFF_FFFE, 33};
        vecs[16] = '{F3_REMU,   32'd5,          32'd0,         5'd0,  32'd5,         1};
        vecs[17] = '{F3_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 5'd17, 32'd0,         33};

        start = 1'b0; funct3 = '0; a = '0; b = '0; rd = '0;
        reset = 1'b1;
        #1;
        chk("reset_busy",    {31'b0, busy},    32'd0);
        chk("reset_done",    {31'b0, done},    32'd0);
        chk("reset_wb_we",   {31'b0, wb_we},   32'd0);
        chk("reset_result",  result,           32'd0);
        chk("reset_wb_addr", {27'b0, wb_addr}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            launch(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd);
            chk($sformatf("v%0d_busy", i), {31'b0, busy}, 32'd1);
            wait_done(60, lat);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_result", i), result, vecs[i].exp);
            chk($sformatf("v%0d_wb_addr", i), {27'b0, wb_addr}, {27'b0, vecs[i].rd});
            chk($sformatf("v%0d_wb_we", i), {31'b0, wb_we}, 32'd1);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_pulse", i), {31'b0, done}, 32'd0);
        end

        // start pulsed at CALC count 5 must be ignored
        launch(F3_DIVU, 32'd100, 32'd7, 5'd3);
        repeat (5) @(posedge clk);
        @(negedge clk);
        start = 1'b1; funct3 = F3_MUL; a = 32'd1000; b = 32'd3; rd = 5'd7;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(40, lat);
        chk("ign_latency", lat, 27);
        chk("ign_result", result, 32'd14);
        chk("ign_wb_addr", {27'b0, wb_addr}, 32'd3);
        @(posedge clk);
        #1;
        chk("ign_no_queue", {30'b0, busy, done}, 32'd0);

        // start held through DONE launches the next op without a gap
        launch(F3_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5);
        repeat (31) @(posedge clk);
        @(negedge clk);
        start = 1'b1; funct3 = F3_DIVU; a = 32'd100; b = 32'd7; rd = 5'd9;
        repeat (2) @(posedge clk);
        #1;
        chk("b2b_done1", {31'b0, done}, 32'd1);
        chk("b2b_result1", result, 32'hFFFF_FFEB);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_done_drop", {31'b0, done}, 32'd0);
        chk("b2b_busy", {31'b0, busy}, 32'd1);
        chk("b2b_result_hold", result, 32'hFFFF_FFEB);
        wait_done(40, lat);
        chk("b2b_latency2", lat, 33);
        chk("b2b_result2", result, 32'd14);
        chk("b2b_wb_addr2", {27'b0, wb_addr}, 32'd9);

        // Reset mid-operation at CALC count 10
        launch(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd21);
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_wb_addr", {27'b0, wb_addr}, 32'd0);
        @(negedge clk) reset = 1'b0;
        cnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (done || busy) cnt++;
        end
        chk("rst_no_done", cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
